// File: rtl/eco_test_pkg.sv
// Shared state encoding and MISR arithmetic for the ECO vector driver.
// Combinational helpers only; no clocked logic here.
package eco_test_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    CAPTURE = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam logic [15:0] MISR_POLY    = 16'h1021;
  localparam logic [15:0] SEED_DEFAULT = 16'hFFFF;

  // One MISR shift: multiply by x modulo the polynomial, then fold in the response.
  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] din);
    return ({sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000)) ^ din;
  endfunction

endpackage

// File: rtl/eco_vec_driver_if.sv
// Stimulus/response bundle between eco_vec_driver (master) and the ECO harness (slave).
// ECO_VEC_CMP_EN adds the golden-response compare signals.
interface eco_vec_driver_if #(
  parameter int A_W   = 4,
  parameter int B_W   = 4,
  parameter int Y_W   = 4,
  parameter int SIG_W = 16
);

  logic                 start;
  logic [A_W-1:0]       vec_a;
  logic [B_W-1:0]       vec_b;
  logic [Y_W-1:0]       resp_y;
  logic                 busy;
  logic                 done;
  logic [A_W+B_W-1:0]   vec_idx;
  logic [SIG_W-1:0]     sig;

`ifdef ECO_VEC_CMP_EN
  logic [Y_W-1:0]       resp_y_ref;
  logic                 mismatch;
  logic [A_W+B_W-1:0]   fail_idx;

  modport master (
    input  start, resp_y, resp_y_ref,
    output vec_a, vec_b, busy, done, vec_idx, sig, mismatch, fail_idx
  );

  modport slave (
    output start, resp_y, resp_y_ref,
    input  vec_a, vec_b, busy, done, vec_idx, sig, mismatch, fail_idx
  );
`else
  modport master (
    input  start, resp_y,
    output vec_a, vec_b, busy, done, vec_idx, sig
  );

  modport slave (
    output start, resp_y,
    input  vec_a, vec_b, busy, done, vec_idx, sig
  );
`endif

endinterface

// File: rtl/eco_vec_driver_misr.sv
// 16-bit MISR: loads SEED on load_seed, folds din in on en; one-cycle update latency.
// No backpressure; load_seed takes priority over en.
module eco_misr16
  import eco_test_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_seed,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sig
);

  logic [15:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load_seed) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = misr_step(sig_q, din);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/eco_vec_driver.sv
// Exhaustive (a,b) sweep into an ECO test circuit with each y compacted into a MISR; each vector
// held SETTLE+1 cycles, no backpressure. Macro ECO_VEC_CMP_EN adds a sticky golden-output compare.
module eco_vec_driver
  import eco_test_pkg::*;
#(
  parameter int          A_W    = 4,
  parameter int          B_W    = 4,
  parameter int          Y_W    = 4,
  parameter int          SIG_W  = 16,
  parameter int          SETTLE = 1,
  parameter logic [15:0] SEED   = SEED_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  eco_vec_driver_if.master bus
);

  localparam int               IDX_W    = A_W + B_W;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [3:0]       CNT_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  // With no settle time every cycle is a capture, so HOLD is never entered.
  localparam state_t           FIRST_ST = (SETTLE == 0) ? CAPTURE : HOLD;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               busy, done;
  logic               start_sweep, capture, last_vec;
  logic [Y_W-1:0]     resp;
  logic [SIG_W-1:0]   misr_din, misr_sig;

  assign start_sweep = (state_q == IDLE) && bus.start;
  assign capture     = (state_q == CAPTURE);
  assign last_vec    = (idx_q == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = FIRST_ST;
      HOLD:    if (cnt_q == CNT_LAST) state_d = CAPTURE;
      CAPTURE: state_d = last_vec ? FINISH : FIRST_ST;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == HOLD) || (state_q == CAPTURE);
    done = (state_q == FINISH);
  end

  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d = '0;
          cnt_d = '0;
        end
      end
      HOLD:    cnt_d = cnt_q + 4'd1;
      CAPTURE: begin
        // The last vector stays on the bus through FINISH and IDLE.
        if (!last_vec) begin
          idx_d = idx_q + IDX_ONE;
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  assign resp     = bus.resp_y;
  assign misr_din = SIG_W'(resp);

  eco_misr16 #(
    .SEED (SEED)
  ) u_misr (
    .clk       (clk),
    .rst       (rst),
    .load_seed (start_sweep),
    .en        (capture),
    .din       (misr_din),
    .sig       (misr_sig)
  );

  assign bus.vec_a   = idx_q[IDX_W-1:B_W];
  assign bus.vec_b   = idx_q[B_W-1:0];
  assign bus.vec_idx = idx_q;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.sig     = misr_sig;

`ifdef ECO_VEC_CMP_EN
  logic             mismatch_q, mismatch_d;
  logic [IDX_W-1:0] fail_idx_q, fail_idx_d;

  // Only the first differing vector of a sweep is recorded.
  always_comb begin
    mismatch_d = mismatch_q;
    fail_idx_d = fail_idx_q;
    if (start_sweep) begin
      mismatch_d = 1'b0;
    end else if (capture && (bus.resp_y != bus.resp_y_ref) && !mismatch_q) begin
      mismatch_d = 1'b1;
      fail_idx_d = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign bus.mismatch = mismatch_q;
  assign bus.fail_idx = fail_idx_q;
`endif

endmodule

// File: tb/tb_eco_vec_driver.sv
// Bench for eco_vec_driver: SETTLE=1 and SETTLE=0 instances driven by random truth-table circuits,
// checked against a polynomial-arithmetic signature model.
module tb_eco_vec_driver;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  eco_vec_driver_if #(.A_W(4), .B_W(4), .Y_W(4), .SIG_W(16)) if_s1 ();
  eco_vec_driver_if #(.A_W(4), .B_W(4), .Y_W(4), .SIG_W(16)) if_s0 ();

  // Circuits under test: one 4-bit response per 8-bit (a,b) vector.
  logic [255:0][3:0] tt1;
  logic [255:0][3:0] tt0;

  assign if_s1.resp_y = tt1[{if_s1.vec_a, if_s1.vec_b}];
  assign if_s0.resp_y = tt0[{if_s0.vec_a, if_s0.vec_b}];

`ifdef ECO_VEC_CMP_EN
  logic [255:0][3:0] flip1;
  assign if_s1.resp_y_ref = tt1[{if_s1.vec_a, if_s1.vec_b}] ^ flip1[{if_s1.vec_a, if_s1.vec_b}];
  assign if_s0.resp_y_ref = if_s0.resp_y;
`endif

  eco_vec_driver #(.SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if_s1));
  eco_vec_driver #(.SETTLE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if_s0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Signature as a polynomial over GF(2): s = s*x mod (x^16+x^12+x^5+1), plus y, for the first n vectors.
  function automatic logic [15:0] sig_model(input logic [255:0][3:0] t, input int n);
    logic [16:0] s;
    s = {1'b0, 16'hFFFF};
    for (int i = 0; i < n; i++) begin
      s = s << 1;
      if (s[16]) s = s ^ 17'h11021;
      s = s ^ {13'b0, t[i]};
    end
    return s[15:0];
  endfunction

  // Runs one sweep on the SETTLE=1 instance; entered and left on a falling edge.
  task automatic sweep1(input string tag, output logic [15:0] fin);
    int          c;
    int          done_at;
    int          busy_bad;
    logic [15:0] first_sig;
    done_at   = 0;
    busy_bad  = 0;
    first_sig = '0;
    if_s1.start = 1'b1;
    @(negedge clk);
    if_s1.start = 1'b0;
    c = 1;
    while (done_at == 0 && c <= 600) begin
      if (c == 3) first_sig = if_s1.sig;
      if (if_s1.busy !== 1'(c <= 512)) busy_bad++;
      if (if_s1.done === 1'b1) done_at = c;
      else begin
        @(negedge clk);
        c++;
      end
    end
    chk({tag, "_done_cycle"}, done_at, 513);
    chk({tag, "_busy_window"}, busy_bad, 0);
    chk({tag, "_first_sig"}, first_sig, sig_model(tt1, 1));
    chk({tag, "_last_idx"}, if_s1.vec_idx, 32'hFF);
    fin = if_s1.sig;
    chk({tag, "_final_sig"}, fin, sig_model(tt1, 256));
    @(negedge clk);
    chk({tag, "_done_pulse"}, if_s1.done, 0);
    chk({tag, "_sig_hold"}, if_s1.sig, sig_model(tt1, 256));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] s_zero, s_gold, s_eco, s_rerun, s_post;
    int          fi, fb, c, done_at, idx_bad;
    logic [7:0]  e;

    rst = 1'b1;
    if_s1.start = 1'b0;
    if_s0.start = 1'b0;
    tt1 = '0;
    tt0 = '0;
`ifdef ECO_VEC_CMP_EN
    flip1 = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy1", if_s1.busy, 0);
    chk("rst_done1", if_s1.done, 0);
    chk("rst_idx1", if_s1.vec_idx, 0);
    chk("rst_sig1", if_s1.sig, 16'hFFFF);
    chk("rst_ab1", {if_s1.vec_a, if_s1.vec_b}, 0);
    chk("rst_sig0", if_s0.sig, 16'hFFFF);
    chk("rst_busy0", if_s0.busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_start", if_s1.busy, 0);

    // Circuit with y tied low: first capture must give EFDF.
    sweep1("zero", s_zero);
    chk("zero_first_const", sig_model(tt1, 1), 16'hEFDF);
    chk("zero_sig_model", s_zero, sig_model(tt1, 256));

    // Random golden circuit, then the same circuit with one gate output changed.
    for (int i = 0; i < 256; i++) tt1[i] = 4'($urandom);
    sweep1("gold", s_gold);
    fi = $urandom_range(0, 255);
    fb = $urandom_range(0, 3);
    tt1[fi][fb] = ~tt1[fi][fb];
    sweep1("eco", s_eco);
    chk("eco_sig_differs", s_eco != s_gold, 1);
    tt1[fi][fb] = ~tt1[fi][fb];
    sweep1("rerun", s_rerun);
    chk("rerun_matches_gold", s_rerun == s_gold, 1);

    // Mid-sweep start is ignored; reset (with start also high) aborts.
    for (int i = 0; i < 256; i++) tt1[i] = 4'($urandom);
    if_s1.start = 1'b1;
    @(negedge clk);
    if_s1.start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (k == 50) if_s1.start = 1'b1;
      if (k == 51) if_s1.start = 1'b0;
      if (k == 60) chk("ignore_start_idx", if_s1.vec_idx, 29);
      if (k < 100) @(negedge clk);
    end
    rst = 1'b1;
    if_s1.start = 1'b1;
    @(negedge clk);
    chk("abort_busy", if_s1.busy, 0);
    chk("abort_done", if_s1.done, 0);
    chk("abort_idx", if_s1.vec_idx, 0);
    chk("abort_ab", {if_s1.vec_a, if_s1.vec_b}, 0);
    chk("abort_sig", if_s1.sig, 16'hFFFF);
    rst = 1'b0;
    if_s1.start = 1'b0;
    @(negedge clk);
    chk("abort_stays_idle", if_s1.busy, 0);
    sweep1("post_rst", s_post);

    // Start held high restarts after one IDLE cycle.
    if_s1.start = 1'b1;
    c = 0;
    while (if_s1.done !== 1'b1 && c < 600) begin
      @(negedge clk);
      c++;
    end
    chk("hold_start_done_seen", if_s1.done, 1);
    @(negedge clk);
    chk("hold_start_idle_gap", if_s1.busy, 0);
    @(negedge clk);
    chk("hold_start_restart", if_s1.busy, 1);
    chk("hold_start_idx0", if_s1.vec_idx, 0);
    chk("hold_start_seed", if_s1.sig, 16'hFFFF);
    if_s1.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // SETTLE=0: new vector every cycle.
    for (int i = 0; i < 256; i++) tt0[i] = 4'($urandom);
    if_s0.start = 1'b1;
    @(negedge clk);
    if_s0.start = 1'b0;
    c = 1;
    done_at = 0;
    idx_bad = 0;
    while (done_at == 0 && c <= 400) begin
      if (c <= 256) begin
        e = 8'(c - 1);
        if (if_s0.vec_idx !== e || if_s0.vec_a !== e[7:4] || if_s0.vec_b !== e[3:0]) idx_bad++;
      end
      if (if_s0.done === 1'b1) done_at = c;
      else begin
        @(negedge clk);
        c++;
      end
    end
    chk("s0_done_cycle", done_at, 257);
    chk("s0_vec_walk", idx_bad, 0);
    chk("s0_final_sig", if_s0.sig, sig_model(tt0, 256));

`ifdef ECO_VEC_CMP_EN
    // Golden circuit differs at 0x37 and 0x90; only 0x37 is recorded.
    for (int i = 0; i < 256; i++) tt1[i] = 4'($urandom);
    flip1[8'h37] = 4'($urandom_range(1, 15));
    flip1[8'h90] = 4'($urandom_range(1, 15));
    if_s1.start = 1'b1;
    @(negedge clk);
    if_s1.start = 1'b0;
    c = 1;
    while (if_s1.done !== 1'b1 && c <= 600) begin
      if (c == 112) chk("cmp_before_37", if_s1.mismatch, 0);
      if (c == 113) chk("cmp_after_37", if_s1.mismatch, 1);
      @(negedge clk);
      c++;
    end
    chk("cmp_done", if_s1.done, 1);
    chk("cmp_sticky", if_s1.mismatch, 1);
    chk("cmp_fail_idx", if_s1.fail_idx, 32'h37);
    chk("cmp_sig_unchanged", if_s1.sig, sig_model(tt1, 256));
    flip1 = '0;
    @(negedge clk);
    if_s1.start = 1'b1;
    @(negedge clk);
    if_s1.start = 1'b0;
    chk("cmp_cleared_on_start", if_s1.mismatch, 0);
    c = 0;
    while (if_s1.done !== 1'b1 && c < 600) begin
      @(negedge clk);
      c++;
    end
    chk("cmp_clean_sweep", if_s1.mismatch, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eco_vec_driver.md
Name: eco_vec_driver

Overview:
- Exhaustive stimulus driver and response compactor for small combinational ECO test circuits: 4-bit `a`, 4-bit `b`, 4-bit `y`.
- Drives every `(a,b)` combination into the circuit under test and captures each `y` into a 16-bit MISR signature.
- Original and ECO-patched netlists are judged equivalent by comparing their final signatures.
- Sits in the ECO test harness as the driving/reading side of the circuit's `a`/`b`/`y` interface.

Parameters:
- A_W, 4, width of `vec_a`
- B_W, 4, width of `vec_b`
- Y_W, 4, width of `resp_y`; must be ≤ SIG_W
- SIG_W, 16, MISR width (fixed polynomial below, valid for 16 only)
- SETTLE, 1, cycles a vector is held before `resp_y` is sampled; range 0..15
- SEED, 16'hFFFF, MISR initial value

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a sweep; sampled only in IDLE
- vec_a  out  A_W  stimulus to circuit input `a`
- vec_b  out  B_W  stimulus to circuit input `b`
- resp_y  in  Y_W  circuit output `y`
- busy  out  1  high while sweeping
- done  out  1  one-cycle pulse when sweep completes
- vec_idx  out  A_W+B_W  index of vector currently presented
- sig  out  SIG_W  running MISR signature; stable after `done`

Behaviour:
- Reset (sync, `rst`=1 at edge):
  - state=IDLE, `vec_a`=0, `vec_b`=0, `vec_idx`=0, `busy`=0, `done`=0, `sig`=SEED, settle counter=0.
  - Reset mid-sweep aborts immediately; there is no partial-result retention.
- Vector mapping: `vec_a` = `vec_idx[A_W+B_W-1:B_W]`, `vec_b` = `vec_idx[B_W-1:0]`. All three are registered and change together.
- FSM states: IDLE, HOLD, CAPTURE, FINISH.
  - IDLE: `busy`=0. `start`=1 → `sig`←SEED, `vec_idx`←0, settle counter←0, go to HOLD (or to CAPTURE if SETTLE=0), `busy`←1.
  - HOLD: settle counter increments each cycle; when it reaches SETTLE-1, go to CAPTURE.
  - CAPTURE: `resp_y` is sampled this edge and the MISR is updated.
    - If `vec_idx` = all-ones, go to FINISH.
    - Otherwise `vec_idx`++, settle counter←0, go to HOLD (or stay in CAPTURE if SETTLE=0).
  - FINISH: `done`=1 for exactly one cycle, `busy`←0, go to IDLE. `vec_idx` and `vec_a`/`vec_b` hold the last vector; `sig` holds.
- Timing: each vector is presented for SETTLE+1 cycles; `resp_y` is sampled on the last of them.
  - Full sweep = 2^(A_W+B_W)·(SETTLE+1) cycles from the first cycle after `start`, plus 1 FINISH cycle.
  - Default: 256·2+1 = 513 cycles.
- MISR update on capture: `fb` = `sig[15]`; `sig` ← ({`sig[14:0]`,1'b0} ^ (`fb` ? 16'h1021 : 0)) ^ zero-extended `resp_y`.
- `start` while not in IDLE is ignored. `start` held high continuously restarts a new sweep on the cycle after FINISH.
- `start` and `rst` in the same cycle: reset wins.
- `resp_y` is treated as combinational from `vec_a`/`vec_b`; X on `resp_y` at capture is a bench error.

Optional Feature:
- Macro `ECO_VEC_CMP_EN`.
- When defined, adds ports:
  - `resp_y_ref` (in, Y_W): golden circuit output.
  - `mismatch` (out, 1): sticky. Set when `resp_y` != `resp_y_ref` at any capture; cleared on `start` and on reset.
  - `fail_idx` (out, A_W+B_W): `vec_idx` of the first mismatch; reset value 0.
- Later mismatches do not overwrite `fail_idx`.
- MISR behaviour is unchanged.
- When not defined: none of these ports or that logic exist.

Decomposition:
- Shared package `eco_test_pkg`:
  - state enum {IDLE, HOLD, CAPTURE, FINISH}
  - MISR polynomial constant 16'h1021
  - default SEED constant 16'hFFFF
  - `misr_step` function
- One sub-module `eco_misr16` (clk, rst, load_seed, en, din, sig), instantiated once. The FSM and counters stay in the top.

Test Plan:
- `resp_y` tied 0, SETTLE=1, `start` pulse → after first capture `sig`=16'hEFDF; `done` pulses at cycle 513; `busy` high cycles 1–512; final `sig` equals bench MISR model.
- `resp_y` driven by bench model of a test circuit; run twice, once with a single-gate-modified model → final signatures differ; unmodified rerun reproduces the identical signature.
- SETTLE=0 → `vec_idx` increments every cycle, 0x00→0xFF; `vec_a`=`idx[7:4]`, `vec_b`=`idx[3:0]` checked each cycle; `done` at cycle 257.
- `rst`=1 at cycle 100 of a sweep → next cycle all outputs at reset values and `sig`=16'hFFFF; a new `start` runs a complete, correct sweep; `start` pulsed mid-sweep has no effect.
- ECO_VEC_CMP_EN: `resp_y_ref` equals `resp_y` except at vectors 0x37 and 0x90 → `mismatch`=1 from the capture of 0x37 onward, `fail_idx`=0x37; next `start` clears `mismatch`.
